regfile_ctx_engine: RTL and testbench

//  Context save/restore sequencer and port arbiter in front of the 32-byte register file.
//  - Idle: core read/write ports pass straight through to the regfile.
//  - SAVE command: stalls the core and streams registers first..last out, one byte at a time, over a valid/ready port.
//  - RESTORE command: stalls the core and writes streamed-in bytes into registers first..last.
//  - Used for interrupt context switch and debug register dump/load.

---
 rtl/regfile_ctx_engine.sv | 200 ++++++++++++++++++++
 tb/tb_regfile_ctx_engine.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine
//   Context save/restore sequencer and port arbiter sitting in front of the
//   byte-addressed register file. When idle, the core's read/write ports pass
//   straight through. A SAVE command streams registers first..last out one
//   byte at a time over a valid/ready port. A RESTORE command writes streamed-in
//   bytes into registers first..last. The core is stalled while the engine owns
//   the regfile.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op                     0 = SAVE, 1 = RESTORE
//   cmd_first/cmd_last         inclusive register index range
//   busy, done, err            status: engine owns regfile / completion pulse / reject pulse
//   core_a, core_b, core_write, core_write_word, core_d, core_Rd, core_stall
//                              core-side regfile ports
//   rf_a, rf_b, rf_write, rf_write_word, rf_d, rf_Rd, rf_Rb
//                              regfile-side ports (rf_Rb valid 1 cycle after rf_b)
//   out_valid/out_ready/out_data   SAVE byte stream
//   in_valid/in_ready/in_data      RESTORE byte stream
module regfile_ctx_engine #(
  parameter int NREGS = 32,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_first,
  input  logic [AW-1:0] cmd_last,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [AW-1:0] core_a,
  input  logic [AW-1:0] core_b,
  input  logic          core_write,
  input  logic          core_write_word,
  input  logic [AW-1:0] core_d,
  input  logic [15:0]   core_Rd,
  output logic          core_stall,
  output logic [AW-1:0] rf_a,
  output logic [AW-1:0] rf_b,
  output logic          rf_write,
  output logic          rf_write_word,
  output logic [AW-1:0] rf_d,
  output logic [15:0]   rf_Rd,
  input  logic [7:0]    rf_Rb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SAVE_RD,
    S_SAVE_OUT,
    S_REST,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] MAX_IDX = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] last_q, last_d;
  logic          op_q, op_d;
  logic          err_q, err_d;

  logic cmd_fire;
  logic cmd_legal;
  logic at_last;

  assign cmd_fire  = cmd_valid && cmd_ready;
  // Range is validated up front, so ptr never walks past MAX_IDX.
  assign cmd_legal = (cmd_first <= cmd_last) && (cmd_last <= MAX_IDX);
  assign at_last   = (ptr_q == last_q);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          op_d    = cmd_op;
          last_d  = cmd_last;
          ptr_d   = cmd_first;
          err_d   = !cmd_legal;
          state_d = cmd_legal ? S_DRAIN : S_DONE;
        end
      end
      // One dead cycle so a core write from the accept cycle lands and the
      // regfile's forwarding path is flushed before the engine reads it.
      S_DRAIN:   state_d = op_q ? S_REST : S_SAVE_RD;
      S_SAVE_RD: state_d = S_SAVE_OUT;
      S_SAVE_OUT: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_SAVE_RD;
          end
        end
      end
      S_REST: begin
        if (in_valid) begin
          if (at_last) begin
            state_d = S_DONE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    err           = 1'b0;
    out_valid     = 1'b0;
    in_ready      = 1'b0;
    rf_a          = '0;
    rf_b          = '0;
    rf_write      = 1'b0;
    rf_write_word = 1'b0;
    rf_d          = '0;
    rf_Rd         = '0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready     = 1'b1;
        busy          = 1'b0;
        rf_a          = core_a;
        rf_b          = core_b;
        rf_write      = core_write;
        rf_write_word = core_write_word;
        rf_d          = core_d;
        rf_Rd         = core_Rd;
      end
      S_DRAIN: ;
      S_SAVE_RD: rf_b = ptr_q;
      // rf_b stays on ptr so rf_Rb (and out_data) is stable under backpressure.
      S_SAVE_OUT: begin
        rf_b      = ptr_q;
        out_valid = 1'b1;
      end
      S_REST: begin
        in_ready = 1'b1;
        rf_write = in_valid;
        rf_d     = ptr_q;
        rf_Rd    = {8'h00, in_data};
      end
      // A rejected command never touched the regfile, so it is not reported
      // as busy even while the done/err pulse is out.
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
        busy = !err_q;
      end
      default: ;
    endcase
  end

  assign core_stall = busy;
  assign out_data   = rf_Rb;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
`timescale 1ns/1ps
module tb_regfile_ctx_engine;
  localparam int NREGS = 32;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_first, cmd_last;
  logic          busy, done, err;
  logic [AW-1:0] core_a, core_b, core_d;
  logic          core_write, core_write_word, core_stall;
  logic [15:0]   core_Rd;
  logic [AW-1:0] rf_a, rf_b, rf_d;
  logic          rf_write, rf_write_word;
  logic [15:0]   rf_Rd;
  logic [7:0]    rf_Rb;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          in_valid, in_ready;
  logic [7:0]    in_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Regfile attached to the DUT's rf_* ports (registered B read).
  logic [7:0] rf_mem  [0:63];
  // Expected register contents, maintained from the command semantics.
  logic [7:0] ref_mem [0:63];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write) begin
      rf_mem[rf_d] <= rf_Rd[7:0];
      if (rf_write_word) rf_mem[rf_d + 6'd1] <= rf_Rd[15:8];
    end
    rf_Rb <= rf_mem[rf_b];
  end

  regfile_ctx_engine #(.NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_first(cmd_first), .cmd_last(cmd_last),
    .busy(busy), .done(done), .err(err),
    .core_a(core_a), .core_b(core_b), .core_write(core_write),
    .core_write_word(core_write_word), .core_d(core_d), .core_Rd(core_Rd),
    .core_stall(core_stall),
    .rf_a(rf_a), .rf_b(rf_b), .rf_write(rf_write), .rf_write_word(rf_write_word),
    .rf_d(rf_d), .rf_Rd(rf_Rd), .rf_Rb(rf_Rb),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_reg(input int idx, input logic [7:0] val);
    step();
    core_write = 1'b1; core_write_word = 1'b0;
    core_d = 6'(idx); core_Rd = {8'h00, val};
    ref_mem[idx] = val;
  endtask

  task automatic test_reset();
    step();
    reset = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_first = 6'd1; cmd_last = 6'd2;
    step(); step(); #1;
    n_tests++;
    if ({cmd_ready, busy, done, err, out_valid, in_ready, core_stall} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b",
               {cmd_ready, busy, done, err, out_valid, in_ready, core_stall}, 7'b1000000);
    end
    step();
    reset = 1'b1; cmd_valid = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [7:0] v;
    step();
    core_write = 1'b1; core_write_word = 1'b0; core_d = 6'd5; core_Rd = 16'h00A5;
    core_a = 6'd7; core_b = 6'd9; #1;
    n_tests++;
    if ({rf_write, rf_d, rf_Rd, core_stall} !== {1'b1, 6'd5, 16'h00A5, 1'b0}) begin
      n_fail++;
      $display("FAIL passthru_fixed: got w=%b d=%0d Rd=%h stall=%b expected w=1 d=5 Rd=00a5 stall=0",
               rf_write, rf_d, rf_Rd, core_stall);
    end
    ref_mem[5] = 8'hA5;
    for (int i = 0; i < NREGS + 4; i++) begin
      step();
      v = 8'($urandom);
      core_a = 6'($urandom); core_b = 6'($urandom);
      if (i < NREGS) begin
        core_write = 1'b1; core_write_word = 1'b0; core_d = 6'(i); core_Rd = {8'h00, v};
        ref_mem[i] = v;
      end else begin
        core_write = 1'b0; core_write_word = 1'($urandom); core_d = 6'($urandom);
        core_Rd = 16'($urandom);
      end
      #1;
      n_tests++;
      if ({rf_write, rf_write_word, rf_d, rf_Rd, rf_a, rf_b, core_stall} !==
          {core_write, core_write_word, core_d, core_Rd, core_a, core_b, 1'b0}) begin
        n_fail++;
        $display("FAIL passthru_rand[%0d]: got %h expected %h", i,
                 {rf_write, rf_write_word, rf_d, rf_Rd, rf_a, rf_b, core_stall},
                 {core_write, core_write_word, core_d, core_Rd, core_a, core_b, 1'b0});
      end
    end
  endtask

  task automatic test_save_fixed();
    logic [7:0] got[$];
    load_reg(16, 8'h11); load_reg(17, 8'h22); load_reg(18, 8'h33); load_reg(19, 8'h44);
    step();
    core_write = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_first = 6'd16; cmd_last = 6'd19; out_ready = 1'b1;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL save_fixed_accept: cmd_ready=%b expected 1", cmd_ready);
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      cmd_valid = 1'b0;
      #1;
      n_tests++;
      if (busy !== ((c >= 1) && (c <= 10))) begin
        n_fail++; $display("FAIL save_fixed_busy c=%0d: got %b expected %b", c, busy, (c >= 1) && (c <= 10));
      end
      n_tests++;
      if ({done, err} !== {(c == 10), 1'b0}) begin
        n_fail++; $display("FAIL save_fixed_done c=%0d: got %b%b expected %b0", c, done, err, (c == 10));
      end
      if (out_valid && out_ready) got.push_back(out_data);
    end
    n_tests++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL save_fixed_count: got %0d bytes expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got[i] !== ref_mem[16 + i]) begin
          n_fail++; $display("FAIL save_fixed_byte[%0d]: got %h expected %h", i, got[i], ref_mem[16 + i]);
        end
      end
    end
  endtask

  task automatic test_save_stall();
    logic [7:0] got[$];
    int stalls = 0;
    bit done_seen = 0;
    step();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_first = 6'd16; cmd_last = 6'd19; out_ready = 1'b1;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      step();
      cmd_valid = 1'b0;
      out_ready = !(got.size() == 1 && stalls < 3);
      #1;
      if (got.size() == 1 && stalls < 3 && out_valid) begin
        n_tests++;
        if (out_data !== 8'h22) begin
          n_fail++; $display("FAIL save_stall_hold[%0d]: got %h expected 22", stalls, out_data);
        end
        stalls++;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (done) done_seen = 1;
    end
    n_tests++;
    if (!done_seen || stalls != 3 || got.size() != 4) begin
      n_fail++;
      $display("FAIL save_stall_flow: done=%0d stalls=%0d bytes=%0d expected 1/3/4", done_seen, stalls, got.size());
    end else begin
      n_tests++;
      if ({got[0], got[1], got[2], got[3]} !== 32'h11223344) begin
        n_fail++; $display("FAIL save_stall_data: got %h expected 11223344", {got[0], got[1], got[2], got[3]});
      end
    end
  endtask

  task automatic test_save_random();
    int f, l;
    logic [7:0] got[$];
    bit done_seen, prev_hold;
    logic [7:0] prev_data;
    for (int t = 0; t < 4; t++) begin
      f = $urandom_range(0, NREGS - 1);
      l = $urandom_range(f, (f + 7 > NREGS - 1) ? NREGS - 1 : f + 7);
      got.delete(); done_seen = 0; prev_hold = 0; prev_data = 8'h00;
      step();
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_first = 6'(f); cmd_last = 6'(l); out_ready = 1'b0;
      for (int c = 0; c < 200 && !done_seen; c++) begin
        step();
        cmd_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        if (prev_hold) begin
          n_tests++;
          if (!out_valid || out_data !== prev_data) begin
            n_fail++; $display("FAIL save_rand_stable t=%0d: valid=%b data=%h expected 1 %h", t, out_valid, out_data, prev_data);
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        if (out_valid && out_ready) got.push_back(out_data);
        if (done) done_seen = 1;
      end
      n_tests++;
      if (!done_seen || got.size() != l - f + 1) begin
        n_fail++; $display("FAIL save_rand_count t=%0d: done=%0d bytes=%0d expected 1 %0d", t, done_seen, got.size(), l - f + 1);
      end else begin
        for (int i = 0; i < got.size(); i++) begin
          n_tests++;
          if (got[i] !== ref_mem[f + i]) begin
            n_fail++; $display("FAIL save_rand_byte t=%0d reg=%0d: got %h expected %h", t, f + i, got[i], ref_mem[f + i]);
          end
        end
      end
    end
  endtask

  task automatic test_restore();
    logic [7:0] dat [3];
    int beat = 0, last_beat_c = -1, done_c = -1;
    dat = '{8'h7E, 8'h7F, 8'h80};
    load_reg(3, 8'($urandom));
    step();
    core_write = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = 6'd0; cmd_last = 6'd2; in_valid = 1'b0;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      step();
      cmd_valid = 1'b0;
      in_valid = (beat < 3) && (c % 3 != 0);
      in_data = (beat < 3) ? dat[beat] : 8'h00;
      #1;
      if (in_valid && in_ready) begin
        ref_mem[beat] = dat[beat];
        beat++;
        last_beat_c = c;
      end
      if (done) done_c = c;
    end
    step();
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (beat != 3 || done_c != last_beat_c + 1) begin
      n_fail++; $display("FAIL restore_timing: beats=%0d done_c=%0d last_beat_c=%0d expected 3 and done one cycle after", beat, done_c, last_beat_c);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rf_mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL restore_reg[%0d]: got %h expected %h", i, rf_mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_restore_random();
    int f, l, beats, bad, bad_idx;
    bit done_seen;
    for (int t = 0; t < 3; t++) begin
      f = $urandom_range(0, NREGS - 1);
      l = $urandom_range(f, (f + 9 > NREGS - 1) ? NREGS - 1 : f + 9);
      beats = 0; done_seen = 0;
      step();
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = 6'(f); cmd_last = 6'(l); in_valid = 1'b0;
      for (int c = 0; c < 200 && !done_seen; c++) begin
        step();
        cmd_valid = 1'b0;
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom);
        #1;
        if (in_valid && in_ready) begin
          ref_mem[f + beats] = in_data;
          beats++;
        end
        if (done) done_seen = 1;
      end
      step();
      in_valid = 1'b0;
      #1;
      bad = 0; bad_idx = -1;
      for (int i = 0; i < NREGS; i++) begin
        if (rf_mem[i] !== ref_mem[i]) begin
          bad++;
          if (bad_idx < 0) bad_idx = i;
        end
      end
      n_tests++;
      if (!done_seen || beats != l - f + 1 || bad != 0) begin
        n_fail++;
        $display("FAIL restore_rand t=%0d: done=%0d beats=%0d (expected %0d) bad_regs=%0d first_bad=%0d",
                 t, done_seen, beats, l - f + 1, bad, bad_idx);
      end
    end
  endtask

  task automatic test_illegal();
    int fs [3];
    int ls [3];
    fs = '{9, 5, 0};
    ls = '{3, 40, 32};
    for (int k = 0; k < 3; k++) begin
      step();
      cmd_valid = 1'b1; cmd_op = 1'($urandom); cmd_first = 6'(fs[k]); cmd_last = 6'(ls[k]);
      in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
      #1;
      n_tests++;
      if (cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL illegal_accept[%0d]: cmd_ready=%b expected 1", k, cmd_ready);
      end
      for (int c = 1; c <= 3; c++) begin
        step();
        cmd_valid = 1'b0;
        #1;
        n_tests++;
        if ({done, err, busy, rf_write, in_ready, out_valid} !== {(c == 1), (c == 1), 4'b0000}) begin
          n_fail++;
          $display("FAIL illegal[%0d] c=%0d: done/err/busy/wr/in_rdy/out_vld=%b expected %b",
                   k, c, {done, err, busy, rf_write, in_ready, out_valid}, {(c == 1), (c == 1), 4'b0000});
        end
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_restore();
    int beat = 0;
    for (int i = 20; i < 24; i++) load_reg(i, 8'($urandom));
    step();
    core_write = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = 6'd20; cmd_last = 6'd23; in_valid = 1'b0;
    for (int c = 0; c < 40 && beat < 2; c++) begin
      step();
      cmd_valid = 1'b0;
      in_valid = 1'b1;
      in_data = 8'($urandom);
      #1;
      if (in_valid && in_ready) begin
        ref_mem[20 + beat] = in_data;
        beat++;
      end
    end
    step();
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    n_tests++;
    if (beat != 2 || {busy, in_ready, core_stall, cmd_ready, done} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_mid_restore_state: beats=%0d busy/in_rdy/stall/cmd_rdy/done=%b expected 2 and 00010",
               beat, {busy, in_ready, core_stall, cmd_ready, done});
    end
    for (int i = 20; i < 24; i++) begin
      n_tests++;
      if (rf_mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL reset_mid_restore_reg[%0d]: got %h expected %h", i, rf_mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r = $urandom_range(0, NREGS - 1);
    int nbytes = 0;
    step();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_first = 6'(r); cmd_last = 6'(r); out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      n_tests++;
      if ({cmd_ready, done} !== {(c % 5 == 0), (c % 5 == 4)}) begin
        n_fail++;
        $display("FAIL b2b c=%0d: cmd_ready/done=%b expected %b", c, {cmd_ready, done}, {(c % 5 == 0), (c % 5 == 4)});
      end
      if (out_valid && out_ready) begin
        nbytes++;
        n_tests++;
        if (out_data !== ref_mem[r]) begin
          n_fail++; $display("FAIL b2b_data: got %h expected %h", out_data, ref_mem[r]);
        end
      end
      step();
    end
    cmd_valid = 1'b0;
    #1;
    n_tests++;
    if (nbytes != 3 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_total: bytes=%0d cmd_ready=%b expected 3 and 1", nbytes, cmd_ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_first = '0; cmd_last = '0;
    core_a = '0; core_b = '0; core_d = '0; core_write = 1'b0; core_write_word = 1'b0;
    core_Rd = '0; out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_passthrough();
    test_save_fixed();
    test_save_stall();
    test_save_random();
    test_restore();
    test_restore_random();
    test_illegal();
    test_reset_mid_restore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
